// File: rtl/mux16_arb_pkg.sv
// Shared types and constants for the 16-way round-robin lane arbiter.
package mux16_arb_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef logic [SEL_W-1:0] sel_t;

  // IDLE re-arbitrates every cycle; LOCKED pins the grant until a last beat.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux16_rr_arbiter_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping 15 -> 0.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             any,
  output sel_t             idx
);

  logic [N_REQ-1:0] rot;
  sel_t             off;

  // Rotate so ptr sits at bit 0, find the lowest set bit, then rotate back.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rot = N_REQ'({req, req} >> ptr);
    any = |req;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
    idx = sel_t'(ptr + off);
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// 16:1 valid/ready arbiter with round-robin grant, packet locking and a
// registered output beat that carries the winning requester's index.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*M-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [M-1:0]   out_data,
  output logic           out_last,
  output sel_t           out_id,
  input  logic           out_ready,
  output logic           busy
);

  if (N != N_REQ) begin : g_bad_n
    $error("mux16_rr_arbiter supports exactly 16 requesters");
  end

  arb_state_e state, state_d;
  sel_t       ptr, ptr_d;
  sel_t       gnt_q, gnt_d;

  logic       pick_any;
  sel_t       pick_idx;
  logic       grant_valid;
  sel_t       grant;
  logic       can_accept;
  logic       accept;
  logic [M-1:0] lane_data;

  rr_pick16 u_pick (
    .req (in_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Grant selection, handshake and lane mux; in_ready is held low during reset.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (state == ARB_LOCKED) begin
      grant_valid = 1'b1;
      grant       = gnt_q;
    end else begin
      grant_valid = pick_any;
      grant       = pick_idx;
    end
    can_accept = !out_valid || out_ready;
    in_ready   = '0;
    if (!rst && can_accept && grant_valid) in_ready[grant] = 1'b1;
    accept    = in_valid[grant] && in_ready[grant];
    lane_data = in_data[grant*M +: M];
  end

  // Next-state: lock on a non-final beat, advance ptr past the winner on a final one.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gnt_d   = gnt_q;
    case (state)
      ARB_IDLE: begin
        if (accept) begin
          if (in_last[grant]) begin
            ptr_d = sel_t'(grant + sel_t'(1));
          end else begin
            state_d = ARB_LOCKED;
            gnt_d   = grant;
          end
        end
      end
      ARB_LOCKED: begin
        if (accept && in_last[grant]) begin
          state_d = ARB_IDLE;
          ptr_d   = sel_t'(gnt_q + sel_t'(1));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      gnt_q <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gnt_q <= gnt_d;
    end
  end

  // Output beat register: load on accept, clear valid when drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lane_data;
      out_last  <= in_last[grant];
      out_id    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state == ARB_LOCKED);

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench: a behavioural arbiter model feeds a scoreboard of
// expected beats, and directed scenarios add point checks.
module tb_mux16_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  in_valid;
  logic [127:0] in_data;
  logic [15:0]  in_last;
  logic [15:0]  in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic [3:0]   out_id;
  logic         out_ready;
  logic         busy;

  mux16_rr_arbiter #(.M(8), .N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Source state per requester
  int          rem  [16];
  int          cnt  [16];
  logic [7:0]  base [16];
  logic [15:0] fire;

  // Reference model state
  int m_ptr, m_gnt;
  bit m_locked, m_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 16; i++) begin
      in_valid[i]        = (rem[i] > 0);
      in_last[i]         = (rem[i] == 1);
      in_data[i*8 +: 8]  = base[i] + 8'(cnt[i]);
    end
  endtask

  task automatic send(input int i, input int len, input logic [7:0] b);
    rem[i]  = len;
    cnt[i]  = 0;
    base[i] = b;
    apply();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      if (fire[i]) begin
        cnt[i]++;
        rem[i]--;
      end
    end
    apply();
  endtask

  task automatic drain(input string tag);
    bit idle = 0;
    for (int n = 0; n < 200 && !idle; n++) begin
      step();
      idle = (q.size() == 0) && !out_valid;
      for (int i = 0; i < 16; i++) if (rem[i] != 0) idle = 0;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  // Model and scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      m_ptr = 0; m_gnt = 0; m_locked = 0; m_ov = 0;
      q.delete();
      fire = '0;
    end else begin
      bit gv, ca, acc;
      int g;
      logic [15:0] exp_rdy;
      gv = 0; g = 0;
      if (m_locked) begin
        gv = 1; g = m_gnt;
      end else begin
        for (int k = 0; k < 16; k++) begin
          if (!gv && in_valid[(m_ptr + k) % 16]) begin
            gv = 1; g = (m_ptr + k) % 16;
          end
        end
      end
      ca      = !m_ov || out_ready;
      exp_rdy = (ca && gv) ? (16'h1 << g) : 16'h0;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("busy", 32'(busy), 32'(m_locked));
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          beat_t e;
          e = q.pop_front();
          check("out_id", 32'(out_id), 32'(e.id));
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
      acc  = gv && in_valid[g] && ca;
      fire = in_valid & in_ready;
      if (acc) begin
        q.push_back('{id: 4'(g), data: in_data[g*8 +: 8], last: in_last[g]});
        if (in_last[g]) begin
          m_locked = 0;
          m_ptr    = (g + 1) % 16;
        end else begin
          m_locked = 1;
          m_gnt    = g;
        end
      end
      m_ov = acc || (m_ov && !out_ready);
    end
  end

  initial begin
    logic [7:0] hold;
    rst       = 1'b1;
    out_ready = 1'b1;
    fire      = '0;
    for (int i = 0; i < 16; i++) send(i, 1, 8'(i));

    // 1: all requesters valid during reset, nothing may be granted
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("first_grant", 32'(in_ready), 32'h0001);

    // 2: sixteen single-beat packets, then requester 0 again after the wrap
    step();
    send(0, 1, 8'd0);
    drain("drain_singles");

    // 3: 4-beat packet from 5 locks out requester 2
    send(5, 4, 8'h50);
    step();
    #1;
    check("locked_busy", 32'(busy), 32'd1);
    send(2, 1, 8'h20);
    step();
    check("lock_blocks_2", 32'(in_ready[2]), 32'd0);
    drain("drain_lock");

    // 4: ptr reaches 15, then wraps to 0
    send(14, 1, 8'hE0);
    drain("drain_14");
    send(15, 1, 8'hF0);
    send(0, 1, 8'h00);
    #1;
    check("wrap_grant15", 32'(in_ready), 32'h8000);
    drain("drain_wrap");

    // 5: backpressure holds the beat and blocks all requesters
    out_ready = 1'b0;
    send(3, 3, 8'h30);
    step();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    hold = out_data;
    for (int c = 0; c < 3; c++) begin
      check("bp_data_stable", 32'(out_data), 32'(hold));
      check("bp_ready_zero", 32'(in_ready), 32'd0);
      if (c < 2) step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h0008);
    drain("drain_bp");

    // 6: reset in the middle of a locked packet
    send(7, 4, 8'h70);
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) rem[i] = 0;
    apply();
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    send(9, 1, 8'h90);
    send(1, 1, 8'h10);
    #1;
    check("post_rst_ptr0", 32'(in_ready), 32'h0002);
    drain("drain_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Shares one M-bit output channel between 16 requesters using valid/ready handshakes.
- Arbitration is round-robin with packet locking: a granted requester keeps the channel until it sends a beat with `last` set.
- The block sits upstream of the shared 16:1 lane-select datapath. It produces the 4-bit select index and a registered output beat.
- It feeds one consumer, such as a systolic-array edge buffer or writeback path.

Parameters:
- M, 8, data width per lane in bits.
- N, 16, requester count. Fixed at 16; the block asserts at elaboration if N != 16.
- SEL_W, 4, select/ID width. Localparam, equal to $clog2(N).

Ports:
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-requester beat valid.
- in_data  input  N*M  packed lanes. Lane i is in_data[i*M +: M].
- in_last  input  N  per-requester end-of-packet flag. Qualified by in_valid.
- in_ready  output  N  per-requester accept. At most one bit is set.
- out_valid  output  1  registered beat valid.
- out_data  output  M  registered beat data.
- out_last  output  1  registered end-of-packet flag.
- out_id  output  SEL_W  index of the requester that sent the current out beat.
- out_ready  input  1  consumer accept.
- busy  output  1  high while in the LOCKED state.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Registered outputs clear: out_valid=0, out_data=0, out_last=0, out_id=0.
  - ptr=0, state=IDLE, busy=0.
  - in_ready is forced to 0 while rst=1.
- Output stage:
  - can_accept = !out_valid || out_ready.
  - A beat is accepted when in_valid[g] && in_ready[g], where in_ready[g] = can_accept && (g is the current grant).
  - On accept, the output register loads lane g data, in_last[g], and g on the next edge; out_valid goes to 1.
  - Latency from accept to out_valid is one cycle.
  - Throughput is 1 beat/cycle when out_ready is held at 1.
  - If out_valid && out_ready and no accept occurs in that cycle, out_valid goes to 0.
  - out_data, out_last and out_id hold their values while out_valid && !out_ready.
- State machine, two states:
  - IDLE:
    - Grant g = first index with in_valid set, scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1.
    - The grant is combinational, so no bubble is inserted on a grant.
    - No valid requester means no grant and in_ready=0.
    - Accept with in_last[g]=0: go to LOCKED and set gnt_q=g.
    - Accept with in_last[g]=1: stay in IDLE and set ptr=(g+1) mod 16, so a single-beat packet releases immediately.
    - If no beat is accepted (out stage full), ptr and state do not change, and the grant is re-evaluated next cycle.
  - LOCKED:
    - Grant is fixed to gnt_q. in_ready is 0 for every other index, even if it is valid.
    - Accept with in_last=1: go to IDLE and set ptr=(gnt_q+1) mod 16.
    - If the locked requester drops in_valid, the lock is held indefinitely. There is no timeout.
- Wrap-around: ptr increments modulo 16 (15 -> 0).
- Simultaneous events:
  - Output drain and new accept in the same cycle are both legal. The register reloads and out_valid stays 1.
  - Requests arriving in the same cycle are resolved by pointer order only.
- Reset mid-packet: the lock and any pending output beat are discarded. No partial beat reaches the output after reset.
- in_ready must not depend combinationally on out_valid of the same cycle through any path other than can_accept. No combinational path from in_valid to in_ready other than the grant scan.

Decomposition:
- Package mux16_arb_pkg holds:
  - localparams N_REQ=16 and SEL_W=4.
  - typedef arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - typedef sel_t = logic [SEL_W-1:0].
- Sub-module rr_pick16:
  - Purely combinational.
  - Inputs: req[15:0] and ptr.
  - Outputs: any and idx (sel_t).
  - Implementation: rotate by ptr, priority-encode, un-rotate.
- Lane data is selected with an indexed part-select on idx inside the top module.

Test Plan:
1. Reset with all in_valid=1, then release:
   - Every in_ready stays 0 during reset; out_valid=0.
   - First accept goes to requester 0 (ptr=0).
2. All 16 requesters send single-beat packets, last=1, data=i, out_ready=1:
   - out_id runs 0,1,...,15,0 on consecutive cycles, with out_data equal to out_id.
3. Requester 5 sends a 4-beat packet (last on beat 4) while requester 2 is valid:
   - Four consecutive out_id=5 beats, the last with out_last=1, then out_id=2.
   - in_ready[2] stays 0 throughout.
4. ptr=15 with requesters 15 and 0 valid:
   - 15 is served first, then 0 (wrap).
5. Backpressure:
   - out_ready=0 for 3 cycles with out_valid=1: out_data is stable and in_ready is all zero.
   - Then out_ready=1: the next beat is accepted the same cycle, with no bubble.
6. Assert rst mid-packet in LOCKED (busy=1):
   - out_valid=0 and busy=0 immediately.
   - After release, arbitration restarts from ptr=0.
